// File: rtl/ball_motion_ctrl.sv
// Ball motion controller for a two-player paddle game.
// Tracks serve/play/game-over state, ball direction, horizontal speed and
// both scores, evaluating ball/paddle/goal coincidences once per frame.
// Optional feature macro: BALL_SPEEDUP_EN -- each honoured paddle hit raises
// the speed by one (saturating at P_SPEED_MAX); when undefined the speed stays
// at P_SPEED_INIT for the whole rally.
module ball_motion_ctrl #(
  parameter int unsigned P_SPEED_INIT   = 1,
  parameter int unsigned P_SPEED_MAX    = 5,
  parameter int unsigned P_SERVE_FRAMES = 60,
  parameter int unsigned P_WIN_SCORE    = 9
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_HReset,
  input  logic       i_VReset,
  input  logic       i_Start,
  input  logic       i_BallVideo,
  input  logic       i_LPaddleVideo,
  input  logic       i_RPaddleVideo,
  input  logic       i_LGoalVideo,
  input  logic       i_RGoalVideo,
  output logic       o_HDir,
  output logic [2:0] o_Speed,
  output logic [3:0] o_ScoreL,
  output logic [3:0] o_ScoreR,
  output logic [1:0] o_State
);

  localparam int unsigned SPEED_W = 3;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned CNT_W   = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SERVE = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  localparam logic [SPEED_W-1:0] SPEED_INIT = SPEED_W'(P_SPEED_INIT);
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(P_SERVE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN_SCORE  = SCORE_W'(P_WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_SAT  = {SCORE_W{1'b1}};

  // Reject parameter sets outside the supported ranges at elaboration
  if (P_SPEED_INIT < 1 || P_SPEED_INIT > 7 ||
      P_SPEED_MAX < P_SPEED_INIT || P_SPEED_MAX > 7 ||
      P_SERVE_FRAMES < 1 || P_SERVE_FRAMES > 255 ||
      P_WIN_SCORE < 1 || P_WIN_SCORE > 15) begin : g_bad_cfg
    $error("ball_motion_ctrl: parameter out of range");
  end

  logic [1:0]         state_q, state_d;
  logic               hdir_q, hdir_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [SPEED_W-1:0] speed_out_q, speed_out_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic [CNT_W-1:0]   serve_cnt_q, serve_cnt_d;
  logic               lhit_q, lhit_d, rhit_q, rhit_d;
  logic               lgoal_q, lgoal_d, rgoal_q, rgoal_d;
  logic               armed_q, armed_d;

  logic               fe_c;
  logic [SPEED_W-1:0] speed_bump_c;

  assign fe_c = i_HReset & i_VReset;

  // Saturating score increment
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_SAT) ? s : s + SCORE_W'(1);
  endfunction

  // Speed after an honoured paddle hit
`ifdef BALL_SPEEDUP_EN
  localparam logic [SPEED_W-1:0] SPEED_MAX = SPEED_W'(P_SPEED_MAX);
  assign speed_bump_c = (speed_q >= SPEED_MAX) ? SPEED_MAX : speed_q + SPEED_W'(1);
`else
  assign speed_bump_c = speed_q;
`endif

  // Sticky coincidence flags; FE-cycle coincidences seed the next frame
  always_comb begin
    lhit_d  = lhit_q  | (i_BallVideo & i_LPaddleVideo);
    rhit_d  = rhit_q  | (i_BallVideo & i_RPaddleVideo);
    lgoal_d = lgoal_q | (i_BallVideo & i_LGoalVideo);
    rgoal_d = rgoal_q | (i_BallVideo & i_RGoalVideo);
    armed_d = armed_q | fe_c;
    if (fe_c) begin
      lhit_d  = i_BallVideo & i_LPaddleVideo;
      rhit_d  = i_BallVideo & i_RPaddleVideo;
      lgoal_d = i_BallVideo & i_LGoalVideo;
      rgoal_d = i_BallVideo & i_RGoalVideo;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    hdir_d      = hdir_q;
    speed_d     = speed_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    serve_cnt_d = serve_cnt_q;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (i_Start) begin
          state_d     = ST_SERVE;
          score_l_d   = '0;
          score_r_d   = '0;
          serve_cnt_d = '0;
          speed_d     = SPEED_INIT;
        end
      end
      ST_SERVE: begin
        if (fe_c) begin
          if (serve_cnt_q == SERVE_LAST) begin
            state_d     = ST_PLAY;
            speed_d     = SPEED_INIT;
            serve_cnt_d = '0;
          end else begin
            serve_cnt_d = serve_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_PLAY: begin
        // The first FE after reset carries no trustworthy flags
        if (fe_c && armed_q) begin
          if (lgoal_q && rgoal_q) begin
            state_d     = ST_SERVE;
            speed_d     = SPEED_INIT;
            serve_cnt_d = '0;
          end else if (lgoal_q) begin
            score_r_d   = sat_inc(score_r_q);
            hdir_d      = 1'b0;
            speed_d     = SPEED_INIT;
            serve_cnt_d = '0;
            state_d     = (score_r_d == WIN_SCORE) ? ST_OVER : ST_SERVE;
          end else if (rgoal_q) begin
            score_l_d   = sat_inc(score_l_q);
            hdir_d      = 1'b1;
            speed_d     = SPEED_INIT;
            serve_cnt_d = '0;
            state_d     = (score_l_d == WIN_SCORE) ? ST_OVER : ST_SERVE;
          end else if (lhit_q && !hdir_q) begin
            hdir_d  = 1'b1;
            speed_d = speed_bump_c;
          end else if (rhit_q && hdir_q) begin
            hdir_d  = 1'b0;
            speed_d = speed_bump_c;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    speed_out_d = (state_d == ST_PLAY) ? speed_d : '0;
  end

  // State and output registers
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= ST_IDLE;
      hdir_q      <= 1'b1;
      speed_q     <= SPEED_INIT;
      speed_out_q <= '0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      serve_cnt_q <= '0;
      lhit_q      <= 1'b0;
      rhit_q      <= 1'b0;
      lgoal_q     <= 1'b0;
      rgoal_q     <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdir_q      <= hdir_d;
      speed_q     <= speed_d;
      speed_out_q <= speed_out_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      serve_cnt_q <= serve_cnt_d;
      lhit_q      <= lhit_d;
      rhit_q      <= rhit_d;
      lgoal_q     <= lgoal_d;
      rgoal_q     <= rgoal_d;
      armed_q     <= armed_d;
    end
  end

  assign o_State  = state_q;
  assign o_HDir   = hdir_q;
  assign o_Speed  = speed_out_q;
  assign o_ScoreL = score_l_q;
  assign o_ScoreR = score_r_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Bench for ball_motion_ctrl: frame-level game model plus literal spot checks.
module tb_ball_motion_ctrl;

  localparam int SPEED_INIT   = 1;
  localparam int SPEED_MAX    = 5;
  localparam int SERVE_FRAMES = 3;
  localparam int WIN_SCORE    = 2;

  logic       i_Clk = 1'b0;
  logic       i_Rst_n = 1'b0;
  logic       i_HReset = 1'b0, i_VReset = 1'b0, i_Start = 1'b0;
  logic       i_BallVideo = 1'b0;
  logic       i_LPaddleVideo = 1'b0, i_RPaddleVideo = 1'b0;
  logic       i_LGoalVideo = 1'b0, i_RGoalVideo = 1'b0;
  logic       o_HDir;
  logic [2:0] o_Speed;
  logic [3:0] o_ScoreL, o_ScoreR;
  logic [1:0] o_State;

  ball_motion_ctrl #(
    .P_SPEED_INIT  (SPEED_INIT),
    .P_SPEED_MAX   (SPEED_MAX),
    .P_SERVE_FRAMES(SERVE_FRAMES),
    .P_WIN_SCORE   (WIN_SCORE)
  ) dut (
    .i_Clk         (i_Clk),
    .i_Rst_n       (i_Rst_n),
    .i_HReset      (i_HReset),
    .i_VReset      (i_VReset),
    .i_Start       (i_Start),
    .i_BallVideo   (i_BallVideo),
    .i_LPaddleVideo(i_LPaddleVideo),
    .i_RPaddleVideo(i_RPaddleVideo),
    .i_LGoalVideo  (i_LGoalVideo),
    .i_RGoalVideo  (i_RGoalVideo),
    .o_HDir        (o_HDir),
    .o_Speed       (o_Speed),
    .o_ScoreL      (o_ScoreL),
    .o_ScoreR      (o_ScoreR),
    .o_State       (o_State)
  );

  always #5 i_Clk = ~i_Clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Game model: 0 idle, 1 serve, 2 play, 3 over
  int m_state, m_hdir, m_speed, m_score_l, m_score_r, m_serve;
  bit m_armed, m_carry_r;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_speed();
    return (m_state == 2) ? m_speed : 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_hdir = 1; m_speed = SPEED_INIT;
    m_score_l = 0; m_score_r = 0; m_serve = 0;
    m_armed = 1'b0; m_carry_r = 1'b0;
  endtask

  task automatic model_start();
    if (m_state == 0 || m_state == 3) begin
      m_state = 1; m_score_l = 0; m_score_r = 0; m_serve = 0; m_speed = SPEED_INIT;
    end
  endtask

  task automatic model_hit();
`ifdef BALL_SPEEDUP_EN
    m_speed = (m_speed < SPEED_MAX) ? m_speed + 1 : SPEED_MAX;
`endif
  endtask

  // What one frame end does to the game, given which events occurred
  task automatic model_fe(input bit lh, input bit rh, input bit lg, input bit rg);
    if (m_state == 1) begin
      m_serve++;
      if (m_serve == SERVE_FRAMES) begin m_state = 2; m_speed = SPEED_INIT; end
    end else if (m_state == 2 && m_armed) begin
      if (lg && rg) begin
        m_state = 1; m_serve = 0; m_speed = SPEED_INIT;
      end else if (lg) begin
        m_score_r = (m_score_r < 15) ? m_score_r + 1 : 15;
        m_hdir = 0; m_speed = SPEED_INIT; m_serve = 0;
        m_state = (m_score_r == WIN_SCORE) ? 3 : 1;
      end else if (rg) begin
        m_score_l = (m_score_l < 15) ? m_score_l + 1 : 15;
        m_hdir = 1; m_speed = SPEED_INIT; m_serve = 0;
        m_state = (m_score_l == WIN_SCORE) ? 3 : 1;
      end else if (lh && m_hdir == 0) begin
        m_hdir = 1; model_hit();
      end else if (rh && m_hdir == 1) begin
        m_hdir = 0; model_hit();
      end
    end
    m_armed = 1'b1;
  endtask

  // Compare every cycle once out of initial reset
  always @(negedge i_Clk) begin
    if (cmp_en) begin
      check("cmp_state",  int'(o_State),  m_state);
      check("cmp_hdir",   int'(o_HDir),   m_hdir);
      check("cmp_speed",  int'(o_Speed),  exp_speed());
      check("cmp_scoreL", int'(o_ScoreL), m_score_l);
      check("cmp_scoreR", int'(o_ScoreR), m_score_r);
    end
  end

  task automatic clear_video();
    i_BallVideo = 1'b0; i_LPaddleVideo = 1'b0; i_RPaddleVideo = 1'b0;
    i_LGoalVideo = 1'b0; i_RGoalVideo = 1'b0;
  endtask

  // One frame: overlap counts per target, decoys, then FE (optionally with a right-paddle hit)
  task automatic run_frame(input int lp, input int rp, input int lg, input int rg, input bit fe_rp);
    int n;
    n = lp;
    if (rp > n) n = rp;
    if (lg > n) n = lg;
    if (rg > n) n = rg;
    for (int i = 0; i < n + 4; i++) begin
      @(negedge i_Clk);
      i_HReset = 1'b0;
      i_VReset = (i == n + 1);
      i_BallVideo    = (i < n);
      i_LPaddleVideo = (i < lp) || (i == n + 2);
      i_RPaddleVideo = (i < rp) || (i == n + 2);
      i_LGoalVideo   = (i < lg) || (i == n + 2);
      i_RGoalVideo   = (i < rg) || (i == n + 2);
    end
    @(negedge i_Clk);
    clear_video(); i_HReset = 1'b1; i_VReset = 1'b0;
    @(negedge i_Clk);
    clear_video(); i_HReset = 1'b1; i_VReset = 1'b1;
    i_BallVideo = fe_rp; i_RPaddleVideo = fe_rp;
    @(posedge i_Clk);
    #1;
    model_fe(lp > 0, (rp > 0) || m_carry_r, lg > 0, rg > 0);
    m_carry_r = fe_rp;
  endtask

  task automatic do_start();
    @(negedge i_Clk);
    clear_video(); i_HReset = 1'b0; i_VReset = 1'b0; i_Start = 1'b1;
    @(posedge i_Clk);
    #1;
    model_start();
    @(negedge i_Clk);
    i_Start = 1'b0;
  endtask

  task automatic serve_out();
    for (int k = 0; k < SERVE_FRAMES; k++) run_frame(0, 0, 0, 0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},  int'(o_State),  0);
    check({tag, "_hdir"},   int'(o_HDir),   1);
    check({tag, "_speed"},  int'(o_Speed),  0);
    check({tag, "_scoreL"}, int'(o_ScoreL), 0);
    check({tag, "_scoreR"}, int'(o_ScoreR), 0);
  endtask

  int exp_seq[6];
  int hit_speed;

  initial begin
    model_reset();
`ifdef BALL_SPEEDUP_EN
    exp_seq = '{2, 3, 4, 5, 5, 5};
    hit_speed = 2;
`else
    exp_seq = '{1, 1, 1, 1, 1, 1};
    hit_speed = 1;
`endif
    repeat (2) @(negedge i_Clk);
    check_reset_values("reset");
    i_Rst_n = 1'b1;
    cmp_en  = 1'b1;

    // Start and serve countdown
    do_start();
    check("start_state", int'(o_State), 1);
    run_frame(0, 0, 0, 0, 1'b0);
    run_frame(0, 0, 0, 0, 1'b0);
    check("serve2_speed", int'(o_Speed), 0);
    check("serve2_state", int'(o_State), 1);
    run_frame(0, 0, 0, 0, 1'b0);
    check("play_state", int'(o_State), 2);
    check("play_speed", int'(o_Speed), 1);
    check("play_hdir",  int'(o_HDir),  1);

    // Right paddle 4-pixel overlap: one flip
    run_frame(0, 4, 0, 0, 1'b0);
    check("rhit_hdir",  int'(o_HDir),  0);
    check("rhit_speed", int'(o_Speed), hit_speed);

    // Left paddle honoured while heading left, then ignored while heading right
    run_frame(4, 0, 0, 0, 1'b0);
    check("lhit_hdir", int'(o_HDir), 1);
    run_frame(4, 0, 0, 0, 1'b0);
    check("lhit_ign_hdir",  int'(o_HDir),  1);
    check("lhit_ign_speed", int'(o_Speed), m_speed);

    // Hit on the FE cycle belongs to the following frame
    run_frame(0, 0, 0, 0, 1'b1);
    check("fe_carry_hold", int'(o_HDir), 1);
    run_frame(0, 0, 0, 0, 1'b0);
    check("fe_carry_flip", int'(o_HDir), 0);

    // Start during play is ignored
    do_start();
    check("start_in_play", int'(o_State), 2);

    // Left goal beats left paddle in the same frame
    run_frame(3, 0, 2, 0, 1'b0);
    check("lgoal_scoreR", int'(o_ScoreR), 1);
    check("lgoal_state",  int'(o_State),  1);
    check("lgoal_speed",  int'(o_Speed),  0);
    check("lgoal_hdir",   int'(o_HDir),   0);

    // Start during serve is ignored
    do_start();
    check("start_in_serve_scoreR", int'(o_ScoreR), 1);

    // Two right goals reach the winning score
    serve_out();
    run_frame(0, 0, 0, 2, 1'b0);
    check("rgoal1_scoreL", int'(o_ScoreL), 1);
    check("rgoal1_hdir",   int'(o_HDir),   1);
    serve_out();
    run_frame(0, 0, 0, 2, 1'b0);
    check("rgoal2_scoreL", int'(o_ScoreL), 2);
    check("rgoal2_state",  int'(o_State),  3);
    run_frame(0, 3, 0, 3, 1'b0);
    check("over_hold_scoreL", int'(o_ScoreL), 2);
    do_start();
    check("restart_scoreL", int'(o_ScoreL), 0);
    check("restart_scoreR", int'(o_ScoreR), 0);
    check("restart_state",  int'(o_State),  1);

    // Both goals in one frame: replay without scoring
    serve_out();
    run_frame(0, 0, 2, 2, 1'b0);
    check("replay_state",  int'(o_State),  1);
    check("replay_scoreL", int'(o_ScoreL), 0);
    check("replay_scoreR", int'(o_ScoreR), 0);

    // Six honoured hits in a row
    serve_out();
    for (int h = 0; h < 6; h++) begin
      if (m_hdir == 1) run_frame(0, 2, 0, 0, 1'b0);
      else             run_frame(2, 0, 0, 0, 1'b0);
      check($sformatf("seq_speed%0d", h), int'(o_Speed), exp_seq[h]);
    end

    // Reset mid-frame with pending hit flags
    @(negedge i_Clk);
    i_HReset = 1'b0; i_VReset = 1'b0;
    i_BallVideo = 1'b1; i_RPaddleVideo = 1'b1; i_LGoalVideo = 1'b1;
    @(negedge i_Clk);
    #2;
    i_Rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_values("midrst");
    @(negedge i_Clk);
    @(negedge i_Clk);
    i_Rst_n = 1'b1;
    clear_video();
    run_frame(0, 3, 3, 0, 1'b0);
    check("post_rst_idle", int'(o_State), 0);
    do_start();
    serve_out();
    check("post_rst_play",   int'(o_State),  2);
    check("post_rst_hdir",   int'(o_HDir),   1);
    check("post_rst_scoreR", int'(o_ScoreR), 0);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ball_motion_ctrl.md
BALL_MOTION_CTRL -- requirements
Module: ball_motion_ctrl

Interface
REQ-001 Parameter P_SPEED_INIT, default 1: ball speed in pixels/frame at every serve (1..7).
REQ-002 Parameter P_SPEED_MAX, default 5: speed ceiling (P_SPEED_INIT..7).
REQ-003 Parameter P_SERVE_FRAMES, default 60: frames the ball is held still before play (1..255).
REQ-004 Parameter P_WIN_SCORE, default 9: score that ends the game (1..15).
REQ-005 i_Clk  input  1  system clock; the only clock.
REQ-006 i_Rst_n  input  1  asynchronous, active-low reset.
REQ-007 i_HReset, i_VReset  input  1 each  timing end-of-line / end-of-frame strobes.
REQ-008 i_Start  input  1  single-cycle start/restart request.
REQ-009 i_BallVideo  input  1  ball pixel active (horizontal AND vertical components).
REQ-010 i_LPaddleVideo, i_RPaddleVideo  input  1 each  paddle pixels active.
REQ-011 i_LGoalVideo, i_RGoalVideo  input  1 each  leftmost/rightmost goal column active.
REQ-012 o_HDir  output  1  ball direction: 1 = right, 0 = left.
REQ-013 o_Speed  output  3  pixels/frame for the horizontal ball counter; 0 = stationary.
REQ-014 o_ScoreL, o_ScoreR  output  4 each  player scores.
REQ-015 o_State  output  2  IDLE=0, SERVE=1, PLAY=2, OVER=3.

Function
REQ-016 Frame end (FE) shall be the cycle where i_HReset and i_VReset are both high.
REQ-017 Four sticky flags (LHit, RHit, LGoal, RGoal) shall set on any cycle where i_BallVideo coincides with the matching input, and shall clear on FE after evaluation; a coincidence on the FE cycle itself shall count toward the next frame.
REQ-018 All outputs shall be registered; state and output changes take effect on the cycle after FE (or after i_Start).
REQ-019 IDLE: o_Speed=0; i_Start -> SERVE, clear scores, serve counter=0.
REQ-020 SERVE: o_Speed=0; count FEs; on the P_SERVE_FRAMES-th FE -> PLAY with speed=P_SPEED_INIT.
REQ-021 PLAY: o_Speed=speed; at FE evaluate in priority order: goal, then paddle.
REQ-022 LGoal only -> o_ScoreR+1, o_HDir=0 (serve toward left); RGoal only -> o_ScoreL+1, o_HDir=1; both -> no score, SERVE (replay).
REQ-023 After a score: if the new score equals P_WIN_SCORE -> OVER, else -> SERVE; speed reset to P_SPEED_INIT.
REQ-024 LHit honoured only while o_HDir=0 -> o_HDir=1; RHit honoured only while o_HDir=1 -> o_HDir=0; hits against the current direction shall be ignored (no double flip).
REQ-025 OVER: o_Speed=0, scores held; i_Start -> SERVE with scores cleared.
REQ-026 i_Start in SERVE or PLAY shall be ignored.
REQ-027 Scores shall saturate at 15 and never wrap.

Reset
REQ-028 i_Rst_n low shall immediately force: state IDLE, o_HDir=1, o_Speed=0, scores 0, flags 0, serve counter 0, speed register P_SPEED_INIT.
REQ-029 Reset asserted mid-frame or mid-PLAY shall discard all pending flags; the first FE after release shall not be evaluated as a hit or goal.

Configuration
REQ-030 Macro BALL_SPEEDUP_EN defined: every honoured paddle hit shall increment speed by 1, saturating at P_SPEED_MAX, taking effect from the next frame.
REQ-031 Macro BALL_SPEEDUP_EN undefined: speed shall stay at P_SPEED_INIT throughout PLAY; P_SPEED_MAX is unused.

Verification
REQ-032 Reset, then i_Start, P_SERVE_FRAMES=3 -> o_Speed=0 for 3 FEs, then o_State=2, o_Speed=1, o_HDir=1.
REQ-033 PLAY, o_HDir=1, ball+right paddle overlap for 4 pixels in one frame -> single flip: o_HDir=0 after FE; speed=2 with BALL_SPEEDUP_EN, 1 without.
REQ-034 PLAY, o_HDir=1, ball+left paddle overlap -> o_HDir stays 1, speed unchanged.
REQ-035 PLAY, ball+left goal overlap and ball+left paddle overlap in the same frame -> o_ScoreR=1, o_State=1, o_Speed=0, o_HDir=0.
REQ-036 P_WIN_SCORE=2, two right-goal frames -> o_ScoreL=2, o_State=3; i_Start -> scores 0, o_State=1.
REQ-037 Six consecutive honoured hits with BALL_SPEEDUP_EN, P_SPEED_MAX=5 -> o_Speed sequence 2,3,4,5,5,5; i_Rst_n pulsed mid-frame -> all outputs at reset values within that cycle.
